// File: rtl/gsensor_pkg.sv
// gsensor_pkg: register map, FSM states and address helpers for the G-sensor responder
package gsensor_pkg;
  localparam logic [5:0] ADDR_DEVID       = 6'h00;
  localparam logic [5:0] ADDR_BW_RATE     = 6'h2C;
  localparam logic [5:0] ADDR_POWER_CTL   = 6'h2D;
  localparam logic [5:0] ADDR_INT_ENABLE  = 6'h2E;
  localparam logic [5:0] ADDR_INT_MAP     = 6'h2F;
  localparam logic [5:0] ADDR_INT_SOURCE  = 6'h30;
  localparam logic [5:0] ADDR_DATA_FORMAT = 6'h31;
  localparam logic [5:0] ADDR_DATAX0      = 6'h32;
  localparam logic [5:0] ADDR_DATAX1      = 6'h33;
  localparam logic [5:0] ADDR_DATAY0      = 6'h34;
  localparam logic [5:0] ADDR_DATAY1      = 6'h35;
  localparam logic [5:0] ADDR_DATAZ0      = 6'h36;
  localparam logic [5:0] ADDR_DATAZ1      = 6'h37;
  localparam logic [5:0] ADDR_FIFO_STATUS = 6'h39;

  typedef enum logic [1:0] {IDLE, CMD, WDATA, RDATA} state_t;

  function automatic logic is_data(input logic [5:0] a);
    return a >= ADDR_DATAX0 && a <= ADDR_DATAZ1;
  endfunction

  function automatic logic is_ro(input logic [5:0] a);
    return a == ADDR_DEVID || a == ADDR_INT_SOURCE || is_data(a) || a == ADDR_FIFO_STATUS;
  endfunction
endpackage

// File: rtl/spi_edge_sync.sv
// spi_edge_sync: synchronises SCLK/CS_N/SDI into clk and flags their edges
module spi_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sclk,
  input  logic csn,
  input  logic sdi,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic cs_rise,
  output logic cs_fall,
  output logic sdi_s
);
  logic [SYNC_STAGES-1:0] sclk_q, csn_q, sdi_q;
  logic sclk_d, csn_d;

  // SCLK and CS_N idle high, so their chains reset high to avoid a false edge after reset
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      sclk_q <= '1;
      csn_q  <= '1;
      sdi_q  <= '0;
      sclk_d <= 1'b1;
      csn_d  <= 1'b1;
    end else begin
      sclk_q <= {sclk_q[SYNC_STAGES-2:0], sclk};
      csn_q  <= {csn_q[SYNC_STAGES-2:0], csn};
      sdi_q  <= {sdi_q[SYNC_STAGES-2:0], sdi};
      sclk_d <= sclk_q[SYNC_STAGES-1];
      csn_d  <= csn_q[SYNC_STAGES-1];
    end

  assign sclk_rise = sclk_q[SYNC_STAGES-1] & ~sclk_d;
  assign sclk_fall = ~sclk_q[SYNC_STAGES-1] & sclk_d;
  assign cs_rise   = csn_q[SYNC_STAGES-1] & ~csn_d;
  assign cs_fall   = ~csn_q[SYNC_STAGES-1] & csn_d;
  assign sdi_s     = sdi_q[SYNC_STAGES-1];
endmodule

// File: rtl/gsensor_spi_responder.sv
// gsensor_spi_responder: ADXL345-style SPI mode-3 register responder; GSENSOR_3WIRE_EN adds 3-wire read-back on SDI
module gsensor_spi_responder
  import gsensor_pkg::*;
#(
  parameter logic [7:0] DEVID       = 8'hE5,
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] BW_RATE_RST = 8'h0A
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        spi_csn,
  input  logic        spi_clk,
  input  logic        spi_sdi,
  output logic        spi_sdo,
  output logic        spi_sdo_oe,
  input  logic [15:0] sample_x,
  input  logic [15:0] sample_y,
  input  logic [15:0] sample_z,
  input  logic        sample_valid,
  output logic [2:1]  int_out,
  output logic [7:0]  power_ctl,
  output logic [7:0]  data_format
`ifdef GSENSOR_3WIRE_EN
  ,
  output logic        spi_sdi_out,
  output logic        spi_sdi_oe
`endif
);
  logic sclk_rise, sclk_fall, cs_rise, cs_fall, sdi_s;

  spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk(clk), .reset_n(reset_n), .sclk(spi_clk), .csn(spi_csn), .sdi(spi_sdi),
    .sclk_rise(sclk_rise), .sclk_fall(sclk_fall), .cs_rise(cs_rise), .cs_fall(cs_fall), .sdi_s(sdi_s)
  );

  state_t      state;
  logic [2:0]  bit_cnt;
  logic [7:0]  sh, tx, rx, rd_data;
  logic [7:0]  regs [64];
  logic [5:0]  addr, next_addr, rd_addr;
  logic        mb, flag, oe, sdo_q, pend, hold, last, set_flag, clr_flag;
  logic [47:0] shadow, src;

  assign rx        = {sh[6:0], sdi_s};
  assign next_addr = mb ? addr + 6'd1 : addr;
  assign rd_addr   = state == CMD ? rx[5:0] : next_addr;
  assign rd_data   = rd_addr == ADDR_INT_SOURCE ? {flag, 7'd0} : regs[rd_addr];
  assign last      = sclk_rise && bit_cnt == 3'd7;
  // a sample arriving while the frame is reading the axis registers waits in the shadow so the burst stays coherent
  assign hold      = state == RDATA && is_data(addr) && !cs_rise;
  assign set_flag  = (sample_valid && !hold) || (cs_rise && pend);
  assign clr_flag  = last && state == RDATA && is_data(addr);
  assign src       = sample_valid && !hold ? {sample_z, sample_y, sample_x} : shadow;

  // frame FSM, register file, sample capture and data-ready flag
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state   <= IDLE;
      bit_cnt <= 3'd0;
      sh      <= 8'd0;
      tx      <= 8'd0;
      addr    <= 6'd0;
      mb      <= 1'b0;
      flag    <= 1'b0;
      oe      <= 1'b0;
      sdo_q   <= 1'b0;
      pend    <= 1'b0;
      shadow  <= 48'd0;
      for (int i = 0; i < 64; i++) regs[i] <= 8'h00;
      regs[ADDR_DEVID]   <= DEVID;
      regs[ADDR_BW_RATE] <= BW_RATE_RST;
    end else begin
      if (cs_rise) begin
        state <= IDLE;
        oe    <= 1'b0;
        pend  <= 1'b0;
      end else if (cs_fall) begin
        state   <= CMD;
        bit_cnt <= 3'd0;
      end else if (state != IDLE) begin
        if (sclk_rise) begin
          sh      <= rx;
          bit_cnt <= bit_cnt + 3'd1;
        end
        if (last && state == CMD) begin
          mb    <= rx[6];
          addr  <= rx[5:0];
          tx    <= rd_data;
          state <= rx[7] ? RDATA : WDATA;
        end
        if (last && state == WDATA) begin
          if (!is_ro(addr)) regs[addr] <= rx;
          addr <= next_addr;
        end
        if (last && state == RDATA) begin
          addr <= next_addr;
          tx   <= rd_data;
        end
        if (sclk_fall && state == RDATA) begin
          sdo_q <= tx[7];
          tx    <= {tx[6:0], 1'b0};
          oe    <= 1'b1;
        end
      end
      if (sample_valid && hold) begin
        shadow <= {sample_z, sample_y, sample_x};
        pend   <= 1'b1;
      end
      if (set_flag)
        for (int i = 0; i < 6; i++) regs[ADDR_DATAX0 + 6'(i)] <= src[8*i +: 8];
      flag <= set_flag ? 1'b1 : clr_flag ? 1'b0 : flag;
    end

  // data-ready interrupt, routed to INT1 or INT2 by INT_MAP bit7
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) int_out <= 2'b00;
    else int_out <= {flag & regs[ADDR_INT_ENABLE][7] & regs[ADDR_INT_MAP][7],
                     flag & regs[ADDR_INT_ENABLE][7] & ~regs[ADDR_INT_MAP][7]};

  assign power_ctl   = regs[ADDR_POWER_CTL];
  assign data_format = regs[ADDR_DATA_FORMAT];
  assign spi_sdo     = sdo_q;
`ifdef GSENSOR_3WIRE_EN
  assign spi_sdo_oe  = oe & ~data_format[6];
  assign spi_sdi_out = sdo_q;
  assign spi_sdi_oe  = oe & data_format[6];
`else
  assign spi_sdo_oe  = oe;
`endif
endmodule

// File: tb/tb_gsensor_spi_responder.sv
// tb_gsensor_spi_responder: table, directed and random checks of the G-sensor SPI responder against a register-map model
module tb_gsensor_spi_responder;
  logic clk = 1'b0, reset_n, spi_csn, spi_clk, spi_sdi, spi_sdo, spi_sdo_oe, sample_valid;
  logic [15:0] sample_x, sample_y, sample_z;
  logic [2:1] int_out;
  logic [7:0] power_ctl, data_format;

  gsensor_spi_responder dut (
    .clk(clk), .reset_n(reset_n), .spi_csn(spi_csn), .spi_clk(spi_clk), .spi_sdi(spi_sdi),
    .spi_sdo(spi_sdo), .spi_sdo_oe(spi_sdo_oe), .sample_x(sample_x), .sample_y(sample_y),
    .sample_z(sample_z), .sample_valid(sample_valid), .int_out(int_out),
    .power_ctl(power_ctl), .data_format(data_format)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] cmd;
    logic [7:0] data;
    logic       rd;
    logic [7:0] exp;
  } vec_t;

  int checks = 0, errors = 0;
  logic [7:0] tb_tx [8], rxb [8], oeb [8];
  logic       oe_after;
  logic [7:0] mreg [64];
  logic       mflag;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic m_ro(input logic [5:0] a);
    return a == 6'h00 || a == 6'h30 || (a >= 6'h32 && a <= 6'h37) || a == 6'h39;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 64; i++) mreg[i] = 8'h00;
    mreg[0]     = 8'hE5;
    mreg[6'h2C] = 8'h0A;
    mflag       = 1'b0;
  endtask

  task automatic m_sample(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    {mreg[6'h33], mreg[6'h32]} = x;
    {mreg[6'h35], mreg[6'h34]} = y;
    {mreg[6'h37], mreg[6'h36]} = z;
    mflag = 1'b1;
  endtask

  task automatic chk_int(input string nm);
    logic [1:0] e;
    e = (mflag && mreg[6'h2E][7]) ? (mreg[6'h2F][7] ? 2'b10 : 2'b01) : 2'b00;
    chk(nm, int_out, e);
  endtask

  // SPI mode 3 master: SDI changes on the fall, SDO is sampled just before each rise
  task automatic xfer(input int nbits);
    @(negedge clk) spi_csn = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      spi_clk = 1'b0;
      spi_sdi = tb_tx[i/8][7 - i%8];
      repeat (8) @(negedge clk);
      rxb[i/8][7 - i%8] = spi_sdo;
      oeb[i/8][7 - i%8] = spi_sdo_oe;
      spi_clk = 1'b1;
      repeat (8) @(negedge clk);
    end
    spi_csn = 1'b1;
    repeat (3) @(negedge clk);
    oe_after = spi_sdo_oe;
    repeat (8) @(negedge clk);
  endtask

  task automatic run_frame(input logic [7:0] cmd, input int n, input string nm);
    logic [5:0] a;
    logic [7:0] e;
    a = cmd[5:0];
    tb_tx[0] = cmd;
    xfer(8 * (n + 1));
    chk({nm, " cmd_oe"}, oeb[0], 8'h00);
    for (int k = 1; k <= n; k++) begin
      if (cmd[7]) begin
        e = a == 6'h30 ? {mflag, 7'd0} : mreg[a];
        if (a >= 6'h32 && a <= 6'h37) mflag = 1'b0;
        chk({nm, " rdata"}, rxb[k], e);
        chk({nm, " data_oe"}, oeb[k], 8'hFF);
      end else begin
        if (!m_ro(a)) mreg[a] = tb_tx[k];
        chk({nm, " wr_oe"}, oeb[k], 8'h00);
      end
      if (cmd[6]) a = a + 6'd1;
    end
    chk({nm, " oe_after_cs"}, oe_after, 1'b0);
  endtask

  task automatic pulse(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    @(negedge clk);
    sample_x = x; sample_y = y; sample_z = z;
    sample_valid = 1'b1;
    @(negedge clk) sample_valid = 1'b0;
  endtask

  vec_t vt [10];
  logic [7:0] burst_exp [6];
  int op, n;
  logic [7:0] c;
  logic [15:0] rx_v, ry_v, rz_v;

  initial begin
    vt[0] = '{8'h80, 8'h00, 1'b1, 8'hE5};
    vt[1] = '{8'h2D, 8'h08, 1'b0, 8'h00};
    vt[2] = '{8'hAD, 8'h00, 1'b1, 8'h08};
    vt[3] = '{8'h00, 8'h12, 1'b0, 8'h00};
    vt[4] = '{8'h80, 8'h00, 1'b1, 8'hE5};
    vt[5] = '{8'hAC, 8'h00, 1'b1, 8'h0A};
    vt[6] = '{8'h31, 8'h0B, 1'b0, 8'h00};
    vt[7] = '{8'hB1, 8'h00, 1'b1, 8'h0B};
    vt[8] = '{8'h30, 8'hFF, 1'b0, 8'h00};
    vt[9] = '{8'hB0, 8'h00, 1'b1, 8'h00};
    burst_exp = '{8'h23, 8'h01, 8'h80, 8'hFF, 8'hFA, 8'h00};

    reset_n = 1'b0; spi_csn = 1'b1; spi_clk = 1'b1; spi_sdi = 1'b0;
    sample_valid = 1'b0; sample_x = 16'h0; sample_y = 16'h0; sample_z = 16'h0;
    m_reset();
    repeat (4) @(negedge clk);
    chk("rst sdo", spi_sdo, 1'b0);
    chk("rst sdo_oe", spi_sdo_oe, 1'b0);
    chk("rst int", int_out, 2'b00);
    chk("rst power_ctl", power_ctl, 8'h00);
    chk("rst data_format", data_format, 8'h00);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      tb_tx[1] = vt[i].data;
      run_frame(vt[i].cmd, 1, "table");
      if (vt[i].rd) chk("table const", rxb[1], vt[i].exp);
    end
    chk("power_ctl mirror", power_ctl, 8'h08);
    chk("data_format mirror", data_format, 8'h0B);

    tb_tx[1] = 8'h80; run_frame(8'h2E, 1, "wr int_en");
    tb_tx[1] = 8'h00; run_frame(8'h2F, 1, "wr int_map");
    pulse(16'h0123, 16'hFF80, 16'h00FA);
    m_sample(16'h0123, 16'hFF80, 16'h00FA);
    @(negedge clk);
    chk("int1 after sample", int_out, 2'b01);
    tb_tx[1] = 8'h80; run_frame(8'h2F, 1, "wr int_map2");
    chk("int2 routed", int_out, 2'b10);
    run_frame(8'hF2, 6, "burst");
    for (int k = 0; k < 6; k++) chk("burst const", rxb[k+1], burst_exp[k]);
    chk("int cleared by read", int_out, 2'b00);
    run_frame(8'hB0, 1, "flag read");
    chk("flag clear const", rxb[1], 8'h00);

    pulse(16'h0123, 16'hFF80, 16'h00FA);
    m_sample(16'h0123, 16'hFF80, 16'h00FA);
    run_frame(8'hB2, 1, "single clr");
    chk("single read clears int", int_out, 2'b00);

    fork
      run_frame(8'hF2, 6, "burst mid");
      begin
        repeat (200) @(negedge clk);
        pulse(16'h0456, 16'h0789, 16'h0001);
      end
    join
    for (int k = 0; k < 6; k++) chk("burst mid coherent", rxb[k+1], burst_exp[k]);
    m_sample(16'h0456, 16'h0789, 16'h0001);
    chk_int("int after shadow");
    run_frame(8'hB6, 1, "shadow applied");
    chk("shadow z const", rxb[1], 8'h01);

    tb_tx[0] = 8'h2D; tb_tx[1] = 8'hFF;
    xfer(13);
    chk("partial write", power_ctl, 8'h08);
    run_frame(8'hAD, 1, "after partial");

    tb_tx[0] = 8'hAD;
    fork
      xfer(24);
      begin
        repeat (200) @(negedge clk);
        chk("oe before reset", spi_sdo_oe, 1'b1);
        reset_n = 1'b0;
        #1;
        chk("oe in reset", spi_sdo_oe, 1'b0);
      end
    join
    m_reset();
    @(negedge clk) reset_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("power_ctl after reset", power_ctl, 8'h00);
    chk("int after reset", int_out, 2'b00);
    run_frame(8'h80, 1, "devid after reset");

    for (int it = 0; it < 40; it++) begin
      op = $urandom_range(0, 2);
      n  = $urandom_range(1, 3);
      c  = 8'($urandom);
      if (op == 0) begin
        c[7] = 1'b0;
        for (int k = 1; k <= n; k++) tb_tx[k] = 8'($urandom);
        run_frame(c, n, "rnd wr");
      end else if (op == 1) begin
        c[7] = 1'b1;
        run_frame(c, n, "rnd rd");
      end else begin
        rx_v = 16'($urandom); ry_v = 16'($urandom); rz_v = 16'($urandom);
        pulse(rx_v, ry_v, rz_v);
        m_sample(rx_v, ry_v, rz_v);
      end
      @(negedge clk);
      chk_int("rnd int");
      chk("rnd power_ctl", power_ctl, mreg[6'h2D]);
      chk("rnd data_format", data_format, mreg[6'h31]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
